// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
//
// Downstream stage of the soda vending FSM. Each one-cycle soda pulse, with
// its 3-bit change code, is queued in a small request FIFO. When the
// dispenser is idle it pops one request, runs the vend motor for VEND_CYCLES
// cycles, then pays the change one coin at a time (dimes first). Every coin
// waits for a coin_done acknowledge from the ejector, bounded by ACK_TIMEOUT.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   soda         one-cycle vend request
//   change[2:0]  change code captured with soda (000..100 = 0..20 cents)
//   coin_done    ejector reports that the last ejected coin has dropped
//   vend_motor   soda motor drive
//   eject_dime   one-cycle pulse: eject one dime
//   eject_nickel one-cycle pulse: eject one nickel
//   busy         dispenser active or requests pending
//   overflow     sticky: a request was dropped because the FIFO was full
//   fault        sticky: ack timeout or invalid change code
// -----------------------------------------------------------------------------
module change_dispenser #(
  parameter int VEND_CYCLES = 8,   // >= 1
  parameter int ACK_TIMEOUT = 16,  // >= 2
  parameter int FIFO_DEPTH  = 2    // power of 2, >= 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       soda,
  input  logic [2:0] change,
  input  logic       coin_done,
  output logic       vend_motor,
  output logic       eject_dime,
  output logic       eject_nickel,
  output logic       busy,
  output logic       overflow,
  output logic       fault
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int VC_W  = (VEND_CYCLES > 1) ? $clog2(VEND_CYCLES) : 1;
  localparam int TM_W  = $clog2(ACK_TIMEOUT);

  typedef enum logic [1:0] {IDLE, VEND, EJECT, WAIT_ACK} state_t;

  state_t            state, state_n;
  logic [4:0]        remaining, remaining_n;
  logic [VC_W-1:0]   vend_cnt, vend_cnt_n;
  logic [TM_W-1:0]   ack_timer, ack_timer_n;
  logic              fault_set;

  // ---------------------------------------------------------------- FIFO --
  logic [2:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              fifo_empty, fifo_full, pop, push, drop;
  logic [2:0]        head;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign head       = mem[rd_ptr];
  assign pop        = (state == IDLE) && !fifo_empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push       = soda && (!fifo_full || pop);
  assign drop       = soda && fifo_full && !pop;

  // NOTE: storage is not reset; validity is carried by count, which is.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= change;
  end

  // -------------------------------------------------------------- decode --
  logic [4:0] head_value;
  logic       head_bad;

  always_comb begin
    head_bad = 1'b0;
    unique case (head)
      3'd0:    head_value = 5'd0;
      3'd1:    head_value = 5'd5;
      3'd2:    head_value = 5'd10;
      3'd3:    head_value = 5'd15;
      3'd4:    head_value = 5'd20;
      default: begin
        head_value = 5'd0;
        head_bad   = 1'b1;
      end
    endcase
  end

  // Greedy coin choice; remaining is always a multiple of 5.
  logic [4:0] coin;
  assign coin = (remaining >= 5'd10) ? 5'd10 : 5'd5;

  // ---------------------------------------------------------- next state --
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_n     = state;
    remaining_n = remaining;
    vend_cnt_n  = vend_cnt;
    ack_timer_n = ack_timer;
    fault_set   = 1'b0;

    unique case (state)
      IDLE: begin
        if (pop) begin
          remaining_n = head_value;
          vend_cnt_n  = VC_W'(VEND_CYCLES - 1);
          fault_set   = head_bad;
          state_n     = VEND;
        end
      end
      VEND: begin
        if (vend_cnt == '0) state_n = (remaining == 5'd0) ? IDLE : EJECT;
        else                vend_cnt_n = vend_cnt - 1'b1;
      end
      EJECT: begin
        ack_timer_n = '0;
        state_n     = WAIT_ACK;
      end
      WAIT_ACK: begin
        // An ack on the timeout edge wins over the timeout.
        if (coin_done) begin
          remaining_n = remaining - coin;
          state_n     = (remaining_n == 5'd0) ? IDLE : EJECT;
        end else if (ack_timer == TM_W'(ACK_TIMEOUT - 1)) begin
          fault_set   = 1'b1;
          remaining_n = 5'd0;
          state_n     = IDLE;
        end else begin
          ack_timer_n = ack_timer + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // ----------------------------------------------------------- registers --
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      vend_cnt  <= '0;
      ack_timer <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      vend_cnt  <= vend_cnt_n;
      ack_timer <= ack_timer_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (drop)      overflow <= 1'b1;
      if (fault_set) fault    <= 1'b1;
    end
  end

  // ------------------------------------------------------------- outputs --
  assign vend_motor   = (state == VEND);
  assign eject_dime   = (state == EJECT) && (remaining >= 5'd10);
  assign eject_nickel = (state == EJECT) && (remaining <  5'd10);
  assign busy         = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_change_dispenser.sv
// -----------------------------------------------------------------------------
// tb_change_dispenser
//
// Scenario tasks driven from one initial block. A transaction-level reference
// (request queue, cents owed, motor cycles left, ack wait count) predicts the
// outputs after every rising edge; coin_done is generated from the reference
// with a configurable ack delay.
// -----------------------------------------------------------------------------
module tb_change_dispenser;

  localparam int VEND_CYCLES = 8;
  localparam int ACK_TIMEOUT = 16;
  localparam int FIFO_DEPTH  = 2;

  logic       clk = 1'b0;
  logic       rst, soda, coin_done;
  logic [2:0] change;
  logic       vend_motor, eject_dime, eject_nickel, busy, overflow, fault;

  change_dispenser #(
    .VEND_CYCLES(VEND_CYCLES), .ACK_TIMEOUT(ACK_TIMEOUT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .soda(soda), .change(change), .coin_done(coin_done),
    .vend_motor(vend_motor), .eject_dime(eject_dime), .eject_nickel(eject_nickel),
    .busy(busy), .overflow(overflow), .fault(fault)
  );

  always #5 clk = ~clk;

  logic [5:0] dut_outs;
  assign dut_outs = {vend_motor, eject_dime, eject_nickel, busy, overflow, fault};

  int checks = 0;
  int errors = 0;

  // ------------------------------------------------------ reference model --
  int q[$];             // pending change codes
  int m_vend_left = 0;  // motor cycles still to run
  int m_owed      = 0;  // cents still to pay
  bit m_eject     = 0;  // a coin is being ejected this cycle
  bit m_waiting   = 0;  // waiting for coin_done
  int m_waited    = 0;  // cycles spent waiting without ack
  bit m_ovf       = 0;
  bit m_fault     = 0;

  int ack_delay = 0;    // ack after this many wait cycles; <0 = never
  bit cd_noise  = 0;    // random coin_done while not waiting

  // observation counters over DUT outputs
  int tick_no = 0, motor_cnt = 0, dime_cnt = 0, nickel_cnt = 0, vend_starts = 0;
  bit prev_motor = 0;

  function automatic int cents_of(int code);
    return (code <= 4) ? code * 5 : 0;
  endfunction

  function automatic bit m_busy();
    return (m_vend_left > 0) || m_eject || m_waiting || (q.size() > 0);
  endfunction

  function automatic logic [5:0] exp_outs();
    return {m_vend_left > 0, m_eject && m_owed >= 10, m_eject && m_owed < 10,
            m_busy(), m_ovf, m_fault};
  endfunction

  task automatic model_edge(input bit r, input bit s, input int c, input bit cd);
    bit active, full, popped;
    int code;
    if (r) begin
      q.delete();
      m_vend_left = 0; m_owed = 0; m_eject = 0; m_waiting = 0; m_waited = 0;
      m_ovf = 0; m_fault = 0;
      return;
    end
    active = (m_vend_left > 0) || m_eject || m_waiting;
    full   = (q.size() == FIFO_DEPTH);
    popped = !active && (q.size() > 0);
    if (m_vend_left > 0) begin
      m_vend_left--;
      if (m_vend_left == 0 && m_owed > 0) m_eject = 1;
    end else if (m_eject) begin
      m_eject = 0; m_waiting = 1; m_waited = 0;
    end else if (m_waiting) begin
      if (cd) begin
        m_owed   -= (m_owed >= 10) ? 10 : 5;
        m_waiting = 0;
        m_eject   = (m_owed > 0);
      end else if (m_waited == ACK_TIMEOUT - 1) begin
        m_fault = 1; m_owed = 0; m_waiting = 0;
      end else begin
        m_waited++;
      end
    end else if (popped) begin
      code        = q.pop_front();
      m_owed      = cents_of(code);
      if (code > 4) m_fault = 1;
      m_vend_left = VEND_CYCLES;
    end
    if (s) begin
      if (!full || popped) q.push_back(c);
      else                 m_ovf = 1;
    end
  endtask

  // One clock: drive inputs, clock edge, advance reference, sample at +1.
  task automatic tick(input bit r, input bit s, input logic [2:0] c);
    bit cd;
    cd = m_waiting && (ack_delay >= 0) && (m_waited >= ack_delay);
    if (!m_waiting && cd_noise) cd = 1'($urandom_range(1, 0));
    rst = r; soda = s; change = c; coin_done = cd;
    @(posedge clk);
    model_edge(r, s, int'(c), cd);
    #1;
    rst = 1'b0; soda = 1'b0; change = 3'($urandom); coin_done = 1'b0;
    tick_no++;
    if (vend_motor) motor_cnt++;
    if (eject_dime) dime_cnt++;
    if (eject_nickel) nickel_cnt++;
    if (vend_motor && !prev_motor) vend_starts++;
    prev_motor = vend_motor;
  endtask

  task automatic clear_counts();
    motor_cnt = 0; dime_cnt = 0; nickel_cnt = 0; vend_starts = 0;
  endtask

  // Run until the reference is idle, comparing every cycle.
  task automatic drain(input string name);
    int n = 0;
    while (m_busy() && n < 300) begin
      tick(0, 0, 3'd0);
      n++;
      checks++;
      if (dut_outs !== exp_outs()) begin
        errors++;
        $display("FAIL %s t=%0d: outs=%b expected=%b", name, tick_no, dut_outs, exp_outs());
      end
    end
    checks++;
    if (m_busy()) begin
      errors++;
      $display("FAIL %s: reference still busy after cycle budget", name);
    end
  endtask

  // --------------------------------------------------------------- tests --
  task automatic test_reset();
    tick(1, 0, 3'd0);
    checks++;
    if (dut_outs !== 6'b0) begin
      errors++;
      $display("FAIL reset: outs=%b expected=000000", dut_outs);
    end
  endtask

  task automatic test_plain_vend();
    ack_delay = 0;
    clear_counts();
    tick(0, 1, 3'b000);
    checks++;
    if (dut_outs !== 6'b000100) begin
      errors++;
      $display("FAIL plain_vend_sampled: outs=%b expected=000100", dut_outs);
    end
    tick(0, 0, 3'd0);
    checks++;
    if (dut_outs !== 6'b100100) begin
      errors++;
      $display("FAIL plain_vend_start: outs=%b expected=100100", dut_outs);
    end
    drain("plain_vend");
    checks++;
    if (motor_cnt != VEND_CYCLES || dime_cnt + nickel_cnt != 0) begin
      errors++;
      $display("FAIL plain_vend_counts: motor=%0d ejects=%0d expected %0d/0",
               motor_cnt, dime_cnt + nickel_cnt, VEND_CYCLES);
    end
  endtask

  task automatic test_change_15();
    ack_delay = 3;
    clear_counts();
    tick(0, 1, 3'b011);
    drain("change_15");
    checks++;
    if (dime_cnt != 1 || nickel_cnt != 1 || fault !== 1'b0) begin
      errors++;
      $display("FAIL change_15: dimes=%0d nickels=%0d fault=%b expected 1/1/0",
               dime_cnt, nickel_cnt, fault);
    end
  endtask

  task automatic test_change_20();
    ack_delay = 0;
    clear_counts();
    tick(0, 1, 3'b100);
    drain("change_20");
    checks++;
    if (dime_cnt != 2 || nickel_cnt != 0) begin
      errors++;
      $display("FAIL change_20: dimes=%0d nickels=%0d expected 2/0", dime_cnt, nickel_cnt);
    end
  endtask

  task automatic test_timeout();
    int eject_t = -1, fault_t = -1;
    ack_delay = -1;
    clear_counts();
    tick(1, 0, 3'd0);
    tick(0, 1, 3'b001);
    while (m_busy() && tick_no < 100000) begin
      tick(0, 0, 3'd0);
      checks++;
      if (dut_outs !== exp_outs()) begin
        errors++;
        $display("FAIL timeout t=%0d: outs=%b expected=%b", tick_no, dut_outs, exp_outs());
      end
      if (eject_nickel && eject_t < 0) eject_t = tick_no;
      if (fault && fault_t < 0) fault_t = tick_no;
      if (tick_no > eject_t + 100 && eject_t >= 0) break;
    end
    // Eject cycle, then ACK_TIMEOUT cycles of waiting, then fault shows.
    checks++;
    if (eject_t < 0 || fault_t - eject_t != ACK_TIMEOUT + 1) begin
      errors++;
      $display("FAIL timeout_latency: got %0d expected %0d", fault_t - eject_t, ACK_TIMEOUT + 1);
    end
    repeat (10) tick(0, 0, 3'd0);
    checks++;
    if (nickel_cnt != 1 || dime_cnt != 0 || busy !== 1'b0 || fault !== 1'b1) begin
      errors++;
      $display("FAIL timeout_end: nickels=%0d dimes=%0d busy=%b fault=%b expected 1/0/0/1",
               nickel_cnt, dime_cnt, busy, fault);
    end
  endtask

  task automatic test_overflow();
    logic [2:0] codes [4] = '{3'b001, 3'b010, 3'b000, 3'b011};
    ack_delay = 0;
    tick(1, 0, 3'd0);
    clear_counts();
    for (int i = 0; i < 4; i++) begin
      tick(0, 1, codes[i]);
      checks++;
      if (dut_outs !== exp_outs()) begin
        errors++;
        $display("FAIL overflow_push%0d: outs=%b expected=%b", i, dut_outs, exp_outs());
      end
      if (i < 3) tick(0, 0, 3'd0);
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_flag: overflow=%b expected=1", overflow);
    end
    drain("overflow");
    checks++;
    if (vend_starts != 3 || dime_cnt != 1 || nickel_cnt != 1) begin
      errors++;
      $display("FAIL overflow_service: vends=%0d dimes=%0d nickels=%0d expected 3/1/1",
               vend_starts, dime_cnt, nickel_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    ack_delay = -1;
    tick(0, 1, 3'b010);
    while (!m_waiting && n < 50) begin
      tick(0, (n == 3), 3'b001);
      n++;
    end
    checks++;
    if (!m_waiting || q.size() != 1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_setup: busy=%b expected=1 with one queued request", busy);
    end
    tick(1, 0, 3'd0);
    checks++;
    if (dut_outs !== 6'b0) begin
      errors++;
      $display("FAIL reset_mid: outs=%b expected=000000", dut_outs);
    end
    ack_delay = 0;
    clear_counts();
    tick(0, 1, 3'b000);
    drain("reset_mid_after");
    checks++;
    if (motor_cnt != VEND_CYCLES || vend_starts != 1) begin
      errors++;
      $display("FAIL reset_mid_revend: motor=%0d vends=%0d expected %0d/1",
               motor_cnt, vend_starts, VEND_CYCLES);
    end
  endtask

  task automatic test_invalid_code();
    tick(1, 0, 3'd0);
    clear_counts();
    tick(0, 1, 3'b110);
    drain("invalid_code");
    checks++;
    if (fault !== 1'b1 || motor_cnt != VEND_CYCLES || dime_cnt + nickel_cnt != 0) begin
      errors++;
      $display("FAIL invalid_code: fault=%b motor=%0d ejects=%0d expected 1/%0d/0",
               fault, motor_cnt, dime_cnt + nickel_cnt, VEND_CYCLES);
    end
  endtask

  task automatic test_random();
    int delays [6] = '{0, 1, 3, ACK_TIMEOUT - 1, ACK_TIMEOUT, -1};
    bit s, r;
    logic [2:0] c;
    tick(1, 0, 3'd0);
    cd_noise = 1;
    for (int i = 0; i < 4000; i++) begin
      if (i % 150 == 0) ack_delay = delays[$urandom_range(5, 0)];
      s = ($urandom_range(5, 0) == 0);
      r = ($urandom_range(599, 0) == 0);
      c = ($urandom_range(9, 0) < 8) ? 3'($urandom_range(4, 0)) : 3'($urandom_range(7, 5));
      tick(r, s, c);
      checks++;
      if (dut_outs !== exp_outs()) begin
        errors++;
        $display("FAIL random t=%0d: outs=%b expected=%b", tick_no, dut_outs, exp_outs());
      end
    end
    cd_noise = 0;
    ack_delay = 0;
    drain("random_drain");
  endtask

  initial begin
    rst = 1'b0; soda = 1'b0; change = 3'd0; coin_done = 1'b0;
    #2;
    test_reset();
    test_plain_vend();
    test_change_15();
    test_change_20();
    test_timeout();
    test_overflow();
    test_reset_mid();
    test_invalid_code();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Downstream stage of the soda vending FSM; consumes its one-cycle soda pulse and 3-bit change code.
- Drives the vend motor, then pays change coin by coin through the dime/nickel ejector, with a completion handshake and a timeout.
- A small request FIFO absorbs back-to-back vends while a payout is still running.

Parameters:
VEND_CYCLES, 8, cycles vend_motor stays high per vend (>=1)
ACK_TIMEOUT, 16, max cycles waiting for coin_done after an eject pulse (>=2)
FIFO_DEPTH, 2, pending request entries (power of 2, >=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
soda  input  1  one-cycle vend request from vending FSM
change  input  3  change code sampled with soda: 000=0, 001=5, 010=10, 011=15, 100=20
coin_done  input  1  ejector mechanism reports the last ejected coin has dropped
vend_motor  output  1  soda motor drive
eject_dime  output  1  one-cycle pulse: eject one dime
eject_nickel  output  1  one-cycle pulse: eject one nickel
busy  output  1  FSM not in IDLE or FIFO non-empty
overflow  output  1  sticky: a request was dropped because the FIFO was full
fault  output  1  sticky: ack timeout or invalid change code

Behaviour:
- Reset:
  - Clock and reset: one clock; reset is synchronous and active-high.
  - rst high at an edge: FSM->IDLE, FIFO empty, remaining=0, timers=0, all outputs 0 from the following cycle.
  - Reset mid-vend or mid-payout abandons the transaction.
- FIFO:
  - Entry = 3-bit change code. Push when soda=1.
  - Push when full drops the request and sets overflow, unless a pop occurs the same edge; push+pop on the same edge when full is legal.
  - Pop only in IDLE.
- Decode on pop:
  - Code decodes to 5-bit remaining value 0/5/10/15/20.
  - Codes 101-111 decode to 0 and set fault; the vend still occurs.
- FSM states: IDLE, VEND, EJECT, WAIT_ACK. Outputs are Moore (decoded from registered state).
- IDLE:
  - If FIFO is non-empty: pop, load remaining, load vend counter = VEND_CYCLES-1, go to VEND.
  - A soda sampled at edge E0 into an empty FIFO is popped at E1; vend_motor is high in the VEND_CYCLES cycles following E1.
- VEND:
  - vend_motor=1; counter decrements each cycle.
  - At 0: if remaining==0 go to IDLE, else go to EJECT.
- EJECT (exactly one cycle):
  - eject_dime=1 if remaining>=10, else eject_nickel=1. Never both.
  - Clear the ack timer; go to WAIT_ACK.
- WAIT_ACK:
  - On coin_done=1: remaining -= coin (10 or 5); if the result is 0 go to IDLE, else go to EJECT.
  - Otherwise the timer increments. When the timer reaches ACK_TIMEOUT-1 with no coin_done: set fault, clear remaining, go to IDLE.
  - coin_done on the same edge as the timeout counts as an ack, not a timeout.
- Coin order: greedy, dimes first; remaining never underflows (all values are multiples of 5).
- coin_done outside WAIT_ACK is ignored.
- Sticky flags: overflow and fault clear only on rst.
- busy: combinational from state and FIFO count; high from the cycle after a soda is sampled until the last transaction returns to IDLE with the FIFO empty.

Test Plan:
1. soda=1, change=000 at one edge -> vend_motor high exactly 8 cycles starting 2 cycles later; no eject pulses; busy drops the cycle after VEND ends.
2. soda, change=011; coin_done 3 cycles after each eject -> after vend: one eject_dime pulse, ack, one eject_nickel pulse, ack, then IDLE; fault=0.
3. soda, change=100, immediate acks -> exactly two eject_dime pulses and zero eject_nickel; remaining ends at 0.
4. soda, change=001, coin_done never asserted -> eject_nickel pulse, then fault=1 exactly ACK_TIMEOUT cycles into WAIT_ACK; FSM returns to IDLE; no further ejects.
5. Four soda pulses 2 cycles apart (codes 001, 010, 000, 011) while the first is vending -> first popped at once, next two queued, fourth dropped with overflow=1; vends for 5, 10, 0 serviced in order.
6. rst pulsed during WAIT_ACK with one request queued -> next cycle all outputs 0, busy=0, flags 0; a later soda vends normally.
7. soda with change=110 -> fault=1, vend_motor runs 8 cycles, no ejects.
